// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared LSU state/size encodings and the data-memory size constant
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
  typedef enum logic {SZ_WORD, SZ_BYTE} lsu_size_t;
  localparam logic [31:0] MEM_SIZE_DEFAULT = 32'h7FF;
endpackage

// File: rtl/lsu_byte_shifter.sv
// lsu_byte_shifter: picks the store byte for the current beat and assembles load data big-endian
module lsu_byte_shifter
  import mips_mem_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int W    = 8
) (
  input  logic [1:0]      cnt,
  input  lsu_size_t       sz,
  input  logic [SIZE-1:0] wdata,
  input  logic [SIZE-1:0] acc,
  input  logic [W-1:0]    mem_rdata,
  output logic [W-1:0]    wbyte,
  output logic [SIZE-1:0] acc_next,
  output logic [SIZE-1:0] load_data
);
  assign wbyte     = wdata[SIZE-1-W*int'(cnt) -: W];
  assign acc_next  = {acc[SIZE-W-1:0], mem_rdata};
  assign load_data = sz == SZ_BYTE ? {{(SIZE-W){1'b0}}, acc[W-1:0]} : acc;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial lw/sw/lb/sb initiator to memoriaDatos; LSU_ALIGN_CHECK_EN rejects unaligned words
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int          SIZE          = 32,
  parameter logic [31:0] SIZE_MEM      = MEM_SIZE_DEFAULT,
  parameter int          SIZE_WORD_MEM = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_byte,
  input  logic [SIZE-1:0]          req_addr,
  input  logic [SIZE-1:0]          req_wdata,
  output logic                     resp_valid,
  output logic [SIZE-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic [SIZE-1:0]          mem_addr,
  output logic [SIZE_WORD_MEM-1:0] mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [SIZE_WORD_MEM-1:0] mem_rdata
);
  lsu_state_t state, state_n;
  lsu_size_t sz;
  logic [SIZE-1:0] base, wdata, acc, acc_next, load_data;
  logic [SIZE_WORD_MEM-1:0] wbyte;
  logic [1:0] cnt;
  logic write, err, rdy, accept, bad, last, access;
  assign accept = req_valid && req_ready;
  assign access = state == ACCESS;
  assign last   = sz == SZ_BYTE ? cnt == 2'd0 : cnt == 2'd3;
`ifdef LSU_ALIGN_CHECK_EN
  assign bad = req_byte ? req_addr >= SIZE_MEM : (req_addr >= SIZE_MEM - 3 || req_addr[1:0] != 2'd0);
`else
  assign bad = req_byte ? req_addr >= SIZE_MEM : req_addr >= SIZE_MEM - 3;
`endif
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (bad ? RESP : ACCESS) : IDLE) :
              access        ? (last ? RESP : ACCESS) : IDLE;
  end
  // rdy holds req_ready low through reset and releases it on the first edge afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
      base  <= '0;
      wdata <= '0;
      acc   <= '0;
      cnt   <= '0;
      write <= 1'b0;
      sz    <= SZ_WORD;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      rdy   <= 1'b1;
      if (state == IDLE && accept) begin
        base  <= req_addr;
        wdata <= req_wdata;
        write <= req_write;
        sz    <= req_byte ? SZ_BYTE : SZ_WORD;
        err   <= bad;
        cnt   <= '0;
        acc   <= '0;
      end else if (access) begin
        cnt <= cnt + 2'd1;
        if (!write) acc <= acc_next;
      end
    end
  end
  lsu_byte_shifter #(.SIZE(SIZE), .W(SIZE_WORD_MEM)) u_shift (
    .cnt(cnt), .sz(sz), .wdata(wdata), .acc(acc), .mem_rdata(mem_rdata),
    .wbyte(wbyte), .acc_next(acc_next), .load_data(load_data)
  );
  assign req_ready  = rdy && state == IDLE;
  assign mem_addr   = access ? base + SIZE'(cnt) : '0;
  assign mem_we     = access && write;
  assign mem_re     = access && !write;
  assign mem_wdata  = mem_we ? wbyte : '0;
  assign resp_valid = state == RESP;
  assign resp_err   = resp_valid && err;
  assign resp_rdata = resp_valid && !err && !write ? load_data : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, reset/abort sequences and random traffic against a byte-array model
module tb_load_store_unit;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_write = 0, req_byte = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, mem_addr;
  logic resp_valid, resp_err, mem_we, mem_re;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [0:2047] = '{default: 8'h00};
  logic [7:0] ref_mem [0:2047] = '{default: 8'h00};
  int pass = 0, total = 0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[10:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[10:0]] <= mem_wdata;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic m_err(input logic b, input logic [31:0] a);
    logic e;
    e = b ? a >= 32'h7FF : a >= 32'h7FC;
`ifdef LSU_ALIGN_CHECK_EN
    if (!b && a[1:0] != 2'd0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int m_lat(input logic b, input logic [31:0] a);
    return m_err(b, a) ? 1 : (b ? 2 : 5);
  endfunction

  function automatic logic [31:0] m_rdata(input logic w, input logic b, input logic [31:0] a);
    if (w || m_err(b, a)) return 32'h0;
    if (b) return {24'h0, ref_mem[a[10:0]]};
    return {ref_mem[a[10:0]], ref_mem[a[10:0]+11'd1], ref_mem[a[10:0]+11'd2], ref_mem[a[10:0]+11'd3]};
  endfunction

  task automatic m_store(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
    if (!w || m_err(b, a)) return;
    for (int i = 0; i < (b ? 1 : 4); i++) ref_mem[a[10:0] + 11'(i)] = d[31-8*i -: 8];
  endtask

  task automatic txn(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic e, output logic [31:0] rd);
    int n, bad;
    @(negedge clk);
    req_valid = 1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
    chk("req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    lat = 0; e = 0; rd = 0; n = 0; bad = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_we || mem_re) begin
        if ((mem_we && mem_re) || mem_we !== w || mem_addr !== a + n || n > 3) bad++;
        else if (w && mem_wdata !== d[31-8*n -: 8]) bad++;
        n++;
      end else if (mem_addr !== 0 || mem_wdata !== 0) bad++;
      if (resp_valid) begin lat = k; e = resp_err; rd = resp_rdata; end
    end
    chk("strobe_count", n, m_err(b, a) ? 0 : (b ? 1 : 4));
    chk("strobe_bad", bad, 0);
  endtask

  typedef struct {
    logic w, b;
    logic [31:0] a, d;
    logic exp_err;
    int exp_lat;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tv[11];

  initial begin
    int lat;
    logic e;
    logic [31:0] rd, a, d;
    logic w, b;
    tv[0]  = '{1, 0, 32'h010, 32'hDEADBEEF, 0, 5, 32'h0};
    tv[1]  = '{0, 0, 32'h010, 32'h0, 0, 5, 32'hDEADBEEF};
    tv[2]  = '{1, 1, 32'h7FE, 32'hA5000000, 0, 2, 32'h0};
    tv[3]  = '{0, 1, 32'h7FE, 32'h0, 0, 2, 32'h000000A5};
    tv[4]  = '{0, 0, 32'h7FC, 32'h0, 1, 1, 32'h0};
    tv[5]  = '{0, 1, 32'h7FF, 32'h0, 1, 1, 32'h0};
    tv[6]  = '{0, 0, 32'h7FB, 32'h0, 0, 5, 32'h000000A5};
    tv[7]  = '{1, 0, 32'h7FC, 32'h12345678, 1, 1, 32'h0};
    tv[8]  = '{0, 1, 32'h013, 32'h0, 0, 2, 32'h000000EF};
`ifdef LSU_ALIGN_CHECK_EN
    tv[6]  = '{0, 0, 32'h7FB, 32'h0, 1, 1, 32'h0};
    tv[9]  = '{0, 0, 32'h011, 32'h0, 1, 1, 32'h0};
`else
    tv[9]  = '{0, 0, 32'h011, 32'h0, 0, 5, 32'hADBEEF00};
`endif
    tv[10] = '{1, 1, 32'h020, 32'h5A000000, 0, 2, 32'h0};

    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_strobes", {resp_valid, resp_err, mem_we, mem_re}, 32'h0);
    chk("rst_addr", mem_addr | {24'h0, mem_wdata} | resp_rdata, 32'h0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    foreach (tv[i]) begin
      txn(tv[i].w, tv[i].b, tv[i].a, tv[i].d, lat, e, rd);
      chk($sformatf("tv%0d_lat", i), lat, tv[i].exp_lat);
      chk($sformatf("tv%0d_err", i), {31'h0, e}, {31'h0, tv[i].exp_err});
      chk($sformatf("tv%0d_rdata", i), rd, tv[i].exp_rd);
      m_store(tv[i].w, tv[i].b, tv[i].a, tv[i].d);
    end

    // reset asserted during the second beat of a store
    @(negedge clk);
    req_valid = 1; req_write = 1; req_byte = 0; req_addr = 32'h40; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_beat2_addr", mem_addr, 32'h41);
    rst_n = 0;
    #1;
    chk("abort_we", {31'h0, mem_we}, 32'h0);
    chk("abort_addr", mem_addr, 32'h0);
    e = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e |= resp_valid | mem_we | mem_re | req_ready;
    end
    rst_n = 1;
    @(negedge clk);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    e |= resp_valid;
    chk("abort_quiet", {31'h0, e}, 32'h0);
    chk("abort_byte0_kept", {24'h0, mem[11'h40]}, 32'h11);
    chk("abort_byte1_unwritten", {24'h0, mem[11'h41]}, 32'h0);
    ref_mem[11'h40] = 8'h11;

    for (int i = 0; i < 300; i++) begin
      w = $urandom_range(0, 1);
      b = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: a = $urandom_range(32'h7F8, 32'h7FF);
        1: a = $urandom;
        default: a = $urandom_range(0, 32'h7FF);
      endcase
      d = $urandom;
      txn(w, b, a, d, lat, e, rd);
      chk($sformatf("rnd%0d_lat", i), lat, m_lat(b, a));
      chk($sformatf("rnd%0d_err", i), {31'h0, e}, {31'h0, m_err(b, a)});
      chk($sformatf("rnd%0d_rdata", i), rd, m_rdata(w, b, a));
      m_store(w, b, a, d);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
